countdown_timer_99: RTL and testbench

//  - Loadable two-digit BCD down-counter (99..00), the countdown counterpart of the 0-99 up counter.
//  - Counts down one step per qualified tick from a preset.
//  - Flags expiry with a one-cycle pulse and a sticky done level.
//  - Sits between the timer control/keypad logic (preset, start, stop) and the display decoders (count).

---
 rtl/countdown_timer_99_if.sv | 23 ++
 rtl/countdown_timer_99.sv | 126 ++++++++++++
 tb/tb_countdown_timer_99.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_99_if.sv
// Control/display bundle for the two-digit BCD countdown timer.
// master = keypad/control side, slave = timer.
interface countdown_timer_99_if;
  logic       tick;
  logic       load;
  logic [7:0] preset;
  logic       start;
  logic       stop;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       expire;

  modport master (
    output tick, load, preset, start, stop,
    input  count, running, done, expire
  );

  modport slave (
    input  tick, load, preset, start, stop,
    output count, running, done, expire
  );
endinterface

// File: rtl/countdown_timer_99.sv
// Loadable 99..00 BCD down-counter with tick prescaler, expiry pulse and sticky done.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: reload from the preset register on expiry.
//
// state | meaning
// IDLE  | holding count, waiting for start (count != 00)
// RUN   | decrementing once per TICK_DIV ticks
// PAUSE | count and prescaler frozen, waiting for start
// DONE  | count reached 00 (one-shot), waiting for load
module countdown_timer_99 #(
  parameter int unsigned TICK_DIV = 1
) (
  input logic                 clk,
  input logic                 reset,
  countdown_timer_99_if.slave tmr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Prescaler counts down from PRESC_TOP; a tick seen at zero is the qualifying one.
  localparam logic [7:0] PRESC_TOP = 8'(TICK_DIV - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] count_q, count_nxt;
  logic [7:0] preset_q, preset_nxt;
  logic [7:0] presc, presc_nxt;
  logic       expire_nxt;
  logic       running_q, done_q, expire_q;
  logic [7:0] preset_clean;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign preset_clean = {clamp_digit(tmr.preset[7:4]), clamp_digit(tmr.preset[3:0])};

  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    preset_nxt = preset_q;
    presc_nxt  = presc;
    expire_nxt = 1'b0;
    if (tmr.load) begin
      count_nxt  = preset_clean;
      preset_nxt = preset_clean;
      presc_nxt  = PRESC_TOP;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!tmr.stop && tmr.start && (count_q != 8'h00)) begin
            state_nxt = RUN;
            presc_nxt = PRESC_TOP;
          end
        end
        RUN: begin
          if (tmr.stop) begin
            state_nxt = PAUSE;
          end else if (tmr.tick) begin
            if (presc != 8'd0) begin
              presc_nxt = presc - 8'd1;
            end else begin
              presc_nxt = PRESC_TOP;
              if (count_q == 8'h01) begin
                expire_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (preset_q != 8'h00) begin
                  count_nxt = preset_q;
                end else begin
                  count_nxt = 8'h00;
                  state_nxt = DONE;
                end
`else
                count_nxt = 8'h00;
                state_nxt = DONE;
`endif
              end else begin
                count_nxt = bcd_dec(count_q);
              end
            end
          end
        end
        PAUSE: begin
          if (!tmr.stop && tmr.start) state_nxt = RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count_q   <= 8'h00;
      preset_q  <= 8'h00;
      presc     <= PRESC_TOP;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expire_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_q   <= count_nxt;
      preset_q  <= preset_nxt;
      presc     <= presc_nxt;
      running_q <= (state_nxt == RUN);
      done_q    <= (state_nxt == DONE);
      expire_q  <= expire_nxt;
    end
  end

  assign tmr.count   = count_q;
  assign tmr.running = running_q;
  assign tmr.done    = done_q;
  assign tmr.expire  = expire_q;

endmodule

// File: tb/tb_countdown_timer_99.sv
// Bench for countdown_timer_99: two instances (TICK_DIV 1 and 3) driven in lockstep,
// directed scenarios plus random traffic against a decimal reference model.
module tb_countdown_timer_99;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_99_if bus0 ();
  countdown_timer_99_if bus1 ();

  countdown_timer_99 #(.TICK_DIV(1)) dut0 (.clk(clk), .reset(reset), .tmr(bus0));
  countdown_timer_99 #(.TICK_DIV(3)) dut1 (.clk(clk), .reset(reset), .tmr(bus1));

  logic [7:0] obs_cnt [2];
  logic [1:0] obs_run, obs_done, obs_exp;
  assign obs_cnt[0] = bus0.count;
  assign obs_cnt[1] = bus1.count;
  assign obs_run  = {bus1.running, bus0.running};
  assign obs_done = {bus1.done,    bus0.done};
  assign obs_exp  = {bus1.expire,  bus0.expire};

  int checks = 0;
  int failures = 0;

  // Reference model: decimal count, decimal preset, ticks accumulated, mode.
  int m_div  [2] = '{1, 3};
  int m_cnt  [2];
  int m_pre  [2];
  int m_acc  [2];
  int m_mode [2];
  bit m_exp  [2];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = 8'(((v / 10) * 16) + (v % 10));
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_acc[k] = 0; m_mode[k] = M_IDLE; m_exp[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit tk, input bit ld, input logic [7:0] pv,
                                     input bit st, input bit sp);
    int t, o;
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = 1'b0;
      if (ld) begin
        t = (pv[7:4] > 9) ? 9 : int'(pv[7:4]);
        o = (pv[3:0] > 9) ? 9 : int'(pv[3:0]);
        m_cnt[k] = t * 10 + o;
        m_pre[k] = m_cnt[k];
        m_acc[k] = 0;
        m_mode[k] = M_IDLE;
      end else if (m_mode[k] == M_IDLE) begin
        if (!sp && st && m_cnt[k] != 0) begin m_mode[k] = M_RUN; m_acc[k] = 0; end
      end else if (m_mode[k] == M_RUN) begin
        if (sp) m_mode[k] = M_PAUSE;
        else if (tk) begin
          m_acc[k]++;
          if (m_acc[k] == m_div[k]) begin
            m_acc[k] = 0;
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_exp[k] = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (m_pre[k] != 0) m_cnt[k] = m_pre[k];
              else m_mode[k] = M_DONE;
`else
              m_mode[k] = M_DONE;
`endif
            end
          end
        end
      end else if (m_mode[k] == M_PAUSE) begin
        if (!sp && st) m_mode[k] = M_RUN;
      end
    end
  endfunction

  task automatic cycle(input bit tk, input bit ld, input logic [7:0] pv,
                       input bit st, input bit sp);
    bus0.tick = tk; bus0.load = ld; bus0.preset = pv; bus0.start = st; bus0.stop = sp;
    bus1.tick = tk; bus1.load = ld; bus1.preset = pv; bus1.start = st; bus1.stop = sp;
    model_step(tk, ld, pv, st, sp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 8'h00, 0, 0);
    model_reset();
    checks++; if (bus0.count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", bus0.count); end
    checks++; if ({obs_run, obs_done, obs_exp} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {obs_run, obs_done, obs_exp}); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.count !== 8'h00 || obs_run !== 2'b00) begin failures++; $display("FAIL reset_release got=%h/%b exp=00/00", bus1.count, obs_run); end
  endtask

  task automatic test_countdown();
    cycle(0, 1, 8'h12, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    checks++; if (bus0.count !== 8'h12 || bus0.running !== 1'b1) begin failures++; $display("FAIL cd_start got=%h run=%b exp=12 run=1", bus0.count, bus0.running); end
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 0, 8'h00, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      checks++; if (bus0.count !== ((i == 12) ? 8'h12 : to_bcd(12 - i))) begin failures++; $display("FAIL cd_step%0d got=%h", i, bus0.count); end
`else
      checks++; if (bus0.count !== to_bcd(12 - i)) begin failures++; $display("FAIL cd_step%0d got=%h exp=%h", i, bus0.count, to_bcd(12 - i)); end
`endif
      checks++; if (bus0.expire !== (i == 12)) begin failures++; $display("FAIL cd_expire%0d got=%b exp=%b", i, bus0.expire, (i == 12)); end
    end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    checks++; if (bus0.done !== 1'b0 || bus0.running !== 1'b1) begin failures++; $display("FAIL cd_end got=done%b run%b exp=done0 run1", bus0.done, bus0.running); end
`else
    checks++; if (bus0.done !== 1'b1 || bus0.running !== 1'b0) begin failures++; $display("FAIL cd_end got=done%b run%b exp=done1 run0", bus0.done, bus0.running); end
    cycle(1, 0, 8'h00, 1, 0);
    checks++; if (bus0.count !== 8'h00 || bus0.done !== 1'b1 || bus0.expire !== 1'b0) begin failures++; $display("FAIL cd_done_hold got=%h done%b exp=00 done1", bus0.count, bus0.done); end
`endif
  endtask

  task automatic test_pause();
    cycle(0, 1, 8'h05, 0, 0);
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL pause_load_clears_done got=%b exp=0", bus0.done); end
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
    cycle(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 8'h00, 0, 0);
      checks++; if (bus0.count !== 8'h03 || bus0.running !== 1'b0) begin failures++; $display("FAIL pause_hold%0d got=%h run%b exp=03 run0", i, bus0.count, bus0.running); end
    end
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h00, 0, 0);
    checks++; if (bus0.count !== 8'h02) begin failures++; $display("FAIL pause_resume got=%h exp=02", bus0.count); end
    checks++; if (bus1.count !== 8'h04) begin failures++; $display("FAIL pause_presc_kept got=%h exp=04", bus1.count); end
  endtask

  task automatic test_sanitise();
    cycle(0, 1, 8'hA7, 0, 0);
    checks++; if (bus0.count !== 8'h97) begin failures++; $display("FAIL sanitise_a7 got=%h exp=97", bus0.count); end
    cycle(0, 1, 8'hFF, 0, 0);
    checks++; if (bus0.count !== 8'h99) begin failures++; $display("FAIL sanitise_ff got=%h exp=99", bus0.count); end
    cycle(0, 1, 8'h3C, 0, 0);
    checks++; if (bus1.count !== 8'h39) begin failures++; $display("FAIL sanitise_3c got=%h exp=39", bus1.count); end
    cycle(0, 1, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 1, 0);
    checks++; if (obs_run !== 2'b00 || bus0.count !== 8'h00) begin failures++; $display("FAIL start_at_zero got=run%b cnt=%h exp=run00 cnt=00", obs_run, bus0.count); end
  endtask

  task automatic test_simultaneous();
    cycle(0, 1, 8'h20, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 1, 8'h50, 0, 0);
    checks++; if (bus0.count !== 8'h50 || bus0.running !== 1'b0) begin failures++; $display("FAIL load_tick got=%h run%b exp=50 run0", bus0.count, bus0.running); end
    cycle(0, 1, 8'h10, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h00, 0, 1);
    checks++; if (bus0.count !== 8'h10 || bus0.running !== 1'b0) begin failures++; $display("FAIL stop_tick got=%h run%b exp=10 run0", bus0.count, bus0.running); end
    cycle(0, 0, 8'h00, 1, 1);
    checks++; if (bus0.running !== 1'b0) begin failures++; $display("FAIL start_stop got=%b exp=0", bus0.running); end
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h00, 0, 0);
    checks++; if (bus0.count !== 8'h09) begin failures++; $display("FAIL dec_10 got=%h exp=09", bus0.count); end
    cycle(0, 1, 8'h01, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 1, 8'h05, 0, 0);
    checks++; if (bus0.expire !== 1'b0 || bus0.count !== 8'h05) begin failures++; $display("FAIL load_at_01 got=exp%b cnt=%h exp=exp0 cnt=05", bus0.expire, bus0.count); end
  endtask

  task automatic test_prescaler();
    logic [7:0] seq [6];
    seq = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00};
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    seq[5] = 8'h02;
`endif
    cycle(0, 1, 8'h02, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 8'h00, 0, 0);
      checks++; if (bus1.count !== seq[i]) begin failures++; $display("FAIL presc_step%0d got=%h exp=%h", i, bus1.count, seq[i]); end
      checks++; if (bus1.expire !== (i == 5)) begin failures++; $display("FAIL presc_expire%0d got=%b exp=%b", i, bus1.expire, (i == 5)); end
    end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    checks++; if (bus1.running !== 1'b1 || bus1.done !== 1'b0) begin failures++; $display("FAIL presc_end got=run%b done%b exp=run1 done0", bus1.running, bus1.done); end
`else
    checks++; if (bus1.running !== 1'b0 || bus1.done !== 1'b1) begin failures++; $display("FAIL presc_end got=run%b done%b exp=run0 done1", bus1.running, bus1.done); end
`endif
  endtask

  task automatic test_reset_midrun();
    cycle(0, 1, 8'h37, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 0, 0);
    checks++; if (bus0.count !== 8'h37 || bus0.running !== 1'b1) begin failures++; $display("FAIL midrun_pre got=%h run%b exp=37 run1", bus0.count, bus0.running); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (bus0.count !== 8'h00 || bus1.count !== 8'h00) begin failures++; $display("FAIL midrun_count got=%h/%h exp=00/00", bus0.count, bus1.count); end
    checks++; if ({obs_run, obs_done, obs_exp} !== 6'b0) begin failures++; $display("FAIL midrun_flags got=%b exp=000000", {obs_run, obs_done, obs_exp}); end
    @(negedge clk); reset = 1'b1;
    cycle(0, 0, 8'h00, 0, 0);
    checks++; if (obs_exp !== 2'b00 || obs_run !== 2'b00) begin failures++; $display("FAIL midrun_after got=exp%b run%b exp=00/00", obs_exp, obs_run); end
  endtask

  task automatic test_random();
    bit tk, ld, st, sp;
    logic [7:0] pv;
    for (int n = 0; n < 800; n++) begin
      tk = ($urandom_range(0, 1) == 1);
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 19) == 0);
      pv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(1, 6));
      cycle(tk, ld, pv, st, sp);
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs_cnt[k] !== to_bcd(m_cnt[k])) begin failures++; $display("FAIL rnd_count dut%0d n=%0d got=%h exp=%h", k, n, obs_cnt[k], to_bcd(m_cnt[k])); end
        checks++; if (obs_run[k] !== (m_mode[k] == M_RUN)) begin failures++; $display("FAIL rnd_running dut%0d n=%0d got=%b exp=%b", k, n, obs_run[k], (m_mode[k] == M_RUN)); end
        checks++; if (obs_done[k] !== (m_mode[k] == M_DONE)) begin failures++; $display("FAIL rnd_done dut%0d n=%0d got=%b exp=%b", k, n, obs_done[k], (m_mode[k] == M_DONE)); end
        checks++; if (obs_exp[k] !== m_exp[k]) begin failures++; $display("FAIL rnd_expire dut%0d n=%0d got=%b exp=%b", k, n, obs_exp[k], m_exp[k]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_pause();
    test_sanitise();
    test_simultaneous();
    test_prescaler();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
